mvm_4_1_8_0: RTL and testbench

//  Serial-load signed matrix-vector multiplier: y = M * x, M is KxK, x is Kx1, K=4, B=8.

---
 rtl/mvm_pkg.sv | 31 +++
 rtl/mvm_mac.sv | 61 ++++++
 rtl/mvm_4_1_8_0.sv | 129 ++++++++++++
 tb/tb_mvm_4_1_8_0.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared types and sizes for the serial-load matrix-vector multiplier.
package mvm_pkg;

  localparam int unsigned K     = 4;
  localparam int unsigned B     = 8;
  localparam int unsigned OUT_W = 2 * B;
  localparam int unsigned IDX_W = $clog2(K * K);
  localparam int unsigned VEC_W = $clog2(K);

  localparam logic [IDX_W-1:0] LastMat = IDX_W'(K * K - 1);
  localparam logic [IDX_W-1:0] LastVec = IDX_W'(K - 1);
  localparam logic [VEC_W-1:0] LastCol = VEC_W'(K - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadM,
    StLoadV,
    StCompute,
    StDone,
    StOutput
  } state_t;

  typedef logic signed [B-1:0]     elem_t;
  typedef logic signed [OUT_W-1:0] res_t;

  // Sign-extend an operand to result width so the product is computed at full width.
  function automatic res_t widen(elem_t v);
    return {{(OUT_W - B){v[B-1]}}, v};
  endfunction

endpackage

// File: rtl/mvm_mac.sv
// Signed multiply-accumulate lane with synchronous clear.
// MVM_SAT_EN: when defined, each accumulate saturates instead of wrapping.
module mvm_mac
  import mvm_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  clr_i,
  input  logic  en_i,
  input  elem_t a_i,
  input  elem_t b_i,
  output res_t  sum_o
);

  res_t acc_q, acc_d;
  res_t prod;

  // Full-width signed product and running sum (acc + product).
  always_comb begin
    prod = widen(a_i) * widen(b_i);
  end

`ifdef MVM_SAT_EN
  logic signed [OUT_W:0] wide;

  // One extra bit exposes overflow; clamp toward the sign of the true sum.
  always_comb begin
    wide = {acc_q[OUT_W-1], acc_q} + {prod[OUT_W-1], prod};
    if (wide[OUT_W] != wide[OUT_W-1]) begin
      sum_o = wide[OUT_W] ? {1'b1, {(OUT_W - 1){1'b0}}} : {1'b0, {(OUT_W - 1){1'b1}}};
    end else begin
      sum_o = wide[OUT_W-1:0];
    end
  end
`else
  // Two's-complement wrap.
  always_comb begin
    sum_o = acc_q + prod;
  end
`endif

  // Clear has priority so the last column of a row restarts the next row at zero.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_o;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mvm_4_1_8_0.sv
// Serial-load signed matrix-vector multiplier, y = M * x, one MAC lane.
// MVM_SAT_EN: when defined, accumulation saturates (see mvm_mac).
module mvm_4_1_8_0
  import mvm_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    loadMatrix,
  input  logic                    loadVector,
  input  logic                    start,
  output logic                    done,
  input  logic signed [B-1:0]     data_in,
  output logic signed [OUT_W-1:0] data_out
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  elem_t m_q [K*K];
  elem_t x_q [K];
  res_t  y_q [K];
  res_t  data_out_q;

  logic [VEC_W-1:0] col;
  logic [VEC_W-1:0] row;
  logic [VEC_W-1:0] out_idx;
  logic             mac_en, mac_clr, row_last;
  res_t             mac_sum;

  // cnt walks M row-major during compute, so its low bits select the column.
  assign col     = cnt_q[VEC_W-1:0];
  assign row     = cnt_q[IDX_W-1:VEC_W];
  assign out_idx = col + VEC_W'(1);

  // State and counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (loadMatrix) begin
          state_d = StLoadM;
        end else if (loadVector) begin
          state_d = StLoadV;
        end else if (start) begin
          state_d = StCompute;
        end
      end
      StLoadM, StCompute: begin
        if (cnt_q == LastMat) begin
          state_d = (state_q == StLoadM) ? StIdle : StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      StLoadV, StOutput: begin
        if (cnt_q == LastVec) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      StDone: begin
        state_d = StOutput;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Decoded controls; the accumulator is kept clear while idle.
  always_comb begin
    done     = (state_q == StDone);
    mac_en   = (state_q == StCompute);
    row_last = mac_en && (col == LastCol);
    mac_clr  = (state_q == StIdle) || row_last;
  end

  mvm_mac u_mac (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .a_i    (m_q[cnt_q]),
    .b_i    (x_q[col]),
    .sum_o  (mac_sum)
  );

  // Operand capture, result write-back and registered output stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < K * K; i++) m_q[i] <= '0;
      for (int i = 0; i < K; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      unique case (state_q)
        StLoadM:   m_q[cnt_q] <= data_in;
        StLoadV:   x_q[col] <= data_in;
        StCompute: if (row_last) y_q[row] <= mac_sum;
        StDone:    data_out_q <= y_q[0];
        StOutput:  if (col != LastCol) data_out_q <= y_q[out_idx];
        default:   ;
      endcase
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_mvm_4_1_8_0.sv
// Scoreboard bench for mvm_4_1_8_0: shadow M/x model, expected y queued per job.
module tb_mvm_4_1_8_0;

  typedef logic signed [7:0]  elem_t;
  typedef logic signed [15:0] res_t;
  typedef elem_t mat_t [16];
  typedef elem_t vec_t [4];

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  loadMatrix = 1'b0;
  logic  loadVector = 1'b0;
  logic  start = 1'b0;
  logic  done;
  elem_t data_in = '0;
  res_t  data_out;

  int checks = 0;
  int failures = 0;

  mat_t mm, tm;
  vec_t xx, tv;
  res_t exp_q [$];

  mvm_4_1_8_0 dut (
    .clk        (clk),
    .reset      (reset),
    .loadMatrix (loadMatrix),
    .loadVector (loadVector),
    .start      (start),
    .done       (done),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  function automatic res_t model_y(int r);
    int acc = 0;
    for (int c = 0; c < 4; c++) begin
      acc += int'(mm[r*4+c]) * int'(xx[c]);
`ifdef MVM_SAT_EN
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
`endif
    end
    return res_t'(acc);
  endfunction

  task automatic set_diag(input int d);
    for (int i = 0; i < 16; i++) tm[i] = (i % 5 == 0) ? elem_t'(d) : elem_t'(0);
  endtask

  // Loads tm; an optional extra word follows the 16 that must be ignored.
  task automatic load_m(input bit extra, input bit with_v);
    @(negedge clk);
    loadMatrix = 1'b1;
    loadVector = with_v;
    start      = with_v;
    @(negedge clk);
    loadMatrix = 1'b0;
    loadVector = 1'b0;
    start      = 1'b0;
    for (int i = 0; i < 16; i++) begin
      data_in = tm[i];
      mm[i]   = tm[i];
      @(negedge clk);
    end
    if (extra) begin
      data_in = 8'sd55;
      @(negedge clk);
    end
    data_in = '0;
  endtask

  task automatic load_v();
    @(negedge clk);
    loadVector = 1'b1;
    @(negedge clk);
    loadVector = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = tv[i];
      xx[i]   = tv[i];
      @(negedge clk);
    end
    data_in = '0;
  endtask

  // Start a job; optionally poke loadVector mid-compute, which must be ignored.
  task automatic run_job(input string name, input bit poke);
    int   lat;
    res_t e;
    for (int r = 0; r < 4; r++) exp_q.push_back(model_y(r));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (poke && lat == 5) begin
        loadVector = 1'b1;
        data_in    = 8'sd99;
      end else begin
        loadVector = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    loadVector = 1'b0;
    data_in    = '0;
    checks++;
    if (done !== 1'b1 || lat != 17) begin
      failures++;
      $display("FAIL %s latency: done=%b after %0d cycles, required done=1 after 17", name, done,
               lat);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'sh7bad;
      checks++;
      if (done !== 1'b0 || data_out !== e) begin
        failures++;
        $display("FAIL %s y[%0d]: data_out=%0d done=%b, required data_out=%0d done=0", name, i,
                 data_out, done, e);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (done !== 1'b0 || data_out !== 16'sd0) begin
      failures++;
      $display("FAIL reset: done=%b data_out=%0d, required 0/0", done, data_out);
    end
    for (int i = 0; i < 16; i++) mm[i] = '0;
    for (int i = 0; i < 4; i++) xx[i] = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_identity();
    set_diag(1);
    load_m(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tv[i] = elem_t'(i + 1);
    load_v();
    run_job("identity", 1'b0);
  endtask

  task automatic test_signed();
    for (int i = 0; i < 16; i++) tm[i] = -8'sd1;
    load_m(1'b0, 1'b0);
    tv[0] = 8'sd127; tv[1] = -8'sd128; tv[2] = 8'sd5; tv[3] = -8'sd5;
    load_v();
    run_job("signed", 1'b0);
  endtask

  task automatic test_corners();
    for (int i = 0; i < 16; i++) tm[i] = -8'sd128;
    for (int i = 0; i < 4; i++) tv[i] = -8'sd128;
    load_m(1'b0, 1'b0);
    load_v();
    run_job("corners", 1'b0);
  endtask

  task automatic test_retention();
    set_diag(1);
    load_m(1'b0, 1'b0);
    tv[0] = 8'sd9; tv[1] = 8'sd8; tv[2] = 8'sd7; tv[3] = 8'sd6;
    load_v();
    run_job("retain_x", 1'b0);
    set_diag(2);
    load_m(1'b0, 1'b0);
    run_job("retain_m", 1'b0);
  endtask

  task automatic test_extra_word();
    for (int i = 0; i < 16; i++) tm[i] = elem_t'(i * 7 - 50);
    tv[0] = 8'sd3; tv[1] = -8'sd11; tv[2] = 8'sd25; tv[3] = -8'sd2;
    load_m(1'b1, 1'b0);
    load_v();
    run_job("extra_word", 1'b0);
    for (int i = 0; i < 16; i++) tm[i] = elem_t'(40 - i * 5);
    tv[0] = -8'sd7; tv[1] = 8'sd13; tv[2] = 8'sd1; tv[3] = 8'sd30;
    load_v();
    load_m(1'b0, 1'b0);
    run_job("vector_first", 1'b0);
  endtask

  // loadMatrix wins over simultaneous loadVector and start.
  task automatic test_priority();
    set_diag(3);
    load_m(1'b0, 1'b1);
    run_job("priority", 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job("ignore_poke", 1'b1);
    run_job("back_to_back", 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || data_out !== 16'sd0) begin
      failures++;
      $display("FAIL reset_mid: done=%b data_out=%0d, required 0/0", done, data_out);
    end
    for (int i = 0; i < 16; i++) mm[i] = '0;
    for (int i = 0; i < 4; i++) xx[i] = '0;
    @(negedge clk);
    reset = 1'b1;
    run_job("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_signed();
    test_corners();
    test_retention();
    test_extra_word();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
